// File: rtl/bcd_sum_display_if.sv
// rtl/bcd_sum_display_if.sv - valid/ready channel carrying a packed BCD sum
//
// Purpose : groups the sum handshake between the BCD adder (master) and the
//           display block (slave).
// Signals : sum_in    [7:0] packed BCD sum, [7:4] tens, [3:0] units
//           sum_valid       sum_in is valid this cycle
//           sum_ready       consumer can accept sum_in this cycle
interface bcd_sum_display_if;
    logic [7:0] sum_in;
    logic       sum_valid;
    logic       sum_ready;

    modport master (
        output sum_in,
        output sum_valid,
        input  sum_ready
    );

    modport slave (
        input  sum_in,
        input  sum_valid,
        output sum_ready
    );
endinterface

// File: rtl/bcd_sum_display.sv
// rtl/bcd_sum_display.sv - captures a packed BCD sum and scans it onto two 7-segment digits
//
// Purpose : accepts an 8-bit packed BCD sum over a valid/ready channel, holds
//           it, and time-multiplexes its two digits onto a 7-segment display.
//           Non-BCD values raise err and show the E glyph.
// Ports   : clk              system clock, rising edge
//           reset            synchronous, active-high reset
//           sum_if (slave)   sum_in / sum_valid / sum_ready handshake
//           seg    [6:0]     segments {g,f,e,d,c,b,a}
//           an     [1:0]     one-hot digit enables, an[0] units, an[1] tens
//           err              held value is not valid BCD
// Params  : REFRESH_DIV      cycles each digit stays lit (>= 2)
//           SEG_ACTIVE_LOW   1 = seg/an inverted at the pins
// Macro   : LEADING_ZERO_BLANK_EN - when defined, a zero tens digit of a
//           valid value is shown blank (its enable stays lit).
module bcd_sum_display #(
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    bcd_sum_display_if.slave          sum_if,
    output logic [6:0]                seg,
    output logic [1:0]                an,
    output logic                      err
);

    localparam int             CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] GLYPH_E     = 7'b1111001;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHOW
    } state_t;

    state_t           state_q;
    logic [7:0]       cap_q;
    logic [7:0]       held_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sel_q;      // 0 = units, 1 = tens
    logic             ready_q;
    logic             err_q;
    logic [6:0]       seg_q;      // logical polarity, 1 = lit
    logic [1:0]       an_q;       // logical polarity, 1 = lit

    logic             handshake;
    logic             wrap;
    logic [CNT_W-1:0] cnt_d;
    logic             sel_d;
    logic [6:0]       show_glyph_d;
    logic [6:0]       load_glyph_d;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0111111;
            4'd1:    g = 7'b0000110;
            4'd2:    g = 7'b1011011;
            4'd3:    g = 7'b1001111;
            4'd4:    g = 7'b1100110;
            4'd5:    g = 7'b1101101;
            4'd6:    g = 7'b1111101;
            4'd7:    g = 7'b0000111;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1101111;
            default: g = GLYPH_E;
        endcase
        return g;
    endfunction

    function automatic logic bcd_error(input logic [7:0] v);
        return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[7:5] != 3'd0);
    endfunction

    // Glyph for one slot of value v. A tens nibble in 2..9 is legal BCD but
    // outside the adder's range, so the whole value is marked bad: both
    // digits show E. A nibble above 9 only poisons its own digit.
    function automatic logic [6:0] slot_glyph(input logic [7:0] v, input logic tens_slot);
        logic       range_bad;
        logic [6:0] g;
        range_bad = (v[7:5] != 3'd0) && (v[7:4] <= 4'd9);
        if (!tens_slot) begin
            g = range_bad ? GLYPH_E : digit_glyph(v[3:0]);
        end else begin
            g = range_bad ? GLYPH_E : digit_glyph(v[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
            if ((v[7:4] == 4'd0) && !bcd_error(v)) begin
                g = GLYPH_BLANK;
            end
`endif
        end
        return g;
    endfunction

    assign handshake = sum_if.sum_valid && ready_q;
    assign wrap      = (cnt_q == CNT_LAST);
    assign cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    assign sel_d     = wrap ? ~sel_q : sel_q;

    // seg is registered from the select value it will sit beside, so seg and
    // an always switch on the same edge.
    assign show_glyph_d = slot_glyph(held_q, sel_d);
    // The first SHOW cycle displays the freshly captured value, so LOAD
    // renders the units glyph straight from the capture register.
    assign load_glyph_d = slot_glyph(cap_q, 1'b0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cap_q   <= 8'h00;
            held_q  <= 8'h00;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            seg_q   <= GLYPH_BLANK;
            an_q    <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    seg_q   <= GLYPH_BLANK;
                    an_q    <= 2'b00;
                    if (handshake) begin
                        cap_q   <= sum_if.sum_in;
                        ready_q <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    held_q  <= cap_q;
                    err_q   <= bcd_error(cap_q);
                    cnt_q   <= '0;
                    sel_q   <= 1'b0;
                    seg_q   <= load_glyph_d;
                    an_q    <= 2'b01;
                    ready_q <= 1'b1;
                    state_q <= ST_SHOW;
                end

                ST_SHOW: begin
                    if (handshake) begin
                        // Any wrap due this cycle is dropped; LOAD restarts
                        // the scan on the units digit.
                        cap_q   <= sum_if.sum_in;
                        ready_q <= 1'b0;
                        state_q <= ST_LOAD;
                    end else begin
                        cnt_q   <= cnt_d;
                        sel_q   <= sel_d;
                        seg_q   <= show_glyph_d;
                        an_q    <= sel_d ? 2'b10 : 2'b01;
                        ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign sum_if.sum_ready = ready_q;
    assign err              = err_q;
    assign seg              = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign an               = SEG_ACTIVE_LOW ? ~an_q  : an_q;

endmodule

// File: tb/tb_bcd_sum_display.sv
// tb/tb_bcd_sum_display.sv - self-checking bench for bcd_sum_display
module tb_bcd_sum_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] gly [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    always #5 clk = ~clk;

    bcd_sum_display_if sif ();

    bcd_sum_display #(
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sum_if (sif),
        .seg    (seg),
        .an     (an),
        .err    (err)
    );

    // Reference model: value-level rules, physical (active-low) polarity.
    function automatic bit ref_err(int v);
        return ((v % 16) > 9) || ((v / 16) > 9) || (v >= 32);
    endfunction

    function automatic logic [6:0] ref_logical(int v, int slot);
        int t = v / 16;
        int u = v % 16;
        bit hi_only = (v >= 32) && (t <= 9);
        if (slot == 0) return (u > 9 || hi_only) ? 7'b1111001 : gly[u];
        if (t > 9 || hi_only) return 7'b1111001;
`ifdef LEADING_ZERO_BLANK_EN
        if (t == 0 && !ref_err(v)) return 7'b0000000;
`endif
        return gly[t];
    endfunction

    // k = cycles since the first SHOW cycle of value v
    function automatic logic [6:0] exp_seg(int v, int k);
        return ~ref_logical(v, (k / DIV) % 2);
    endfunction

    function automatic logic [1:0] exp_an(int k);
        return (((k / DIV) % 2) == 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic wait_ready();
        int budget = 0;
        while (sif.sum_ready !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        n_tests++;
        if (sif.sum_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_ready timeout sum_ready=%b required=1", sif.sum_ready);
        end
    endtask

    // Transfers v and returns in the first SHOW cycle (k = 0).
    task automatic send(int v);
        wait_ready();
        sif.sum_in    = v[7:0];
        sif.sum_valid = 1'b1;
        @(posedge clk); #1;
        sif.sum_valid = 1'b0;
        sif.sum_in    = 8'($urandom);
        n_tests++;
        if (sif.sum_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ready v=%h sum_ready=%b required=0", v, sif.sum_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        sif.sum_valid = 1'b0;
        sif.sum_in    = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (seg !== 7'h7F || an !== 2'b11 || err !== 1'b0 || sif.sum_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values seg=%b an=%b err=%b rdy=%b required 1111111/11/0/0",
                     seg, an, err, sif.sum_ready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (seg !== 7'h7F || an !== 2'b11 || err !== 1'b0 || sif.sum_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_%0d seg=%b an=%b err=%b rdy=%b required 1111111/11/0/1",
                         i, seg, an, err, sif.sum_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_scan();
        send(8'h17);
        for (int k = 0; k < 3 * DIV; k++) begin
            n_tests++;
            if (seg !== exp_seg(8'h17, k) || an !== exp_an(k) || err !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_17 k=%0d seg=%b an=%b err=%b required %b/%b/0",
                         k, seg, an, err, exp_seg(8'h17, k), exp_an(k));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_leading_zero();
        send(8'h05);
        for (int k = 0; k < 2 * DIV; k++) begin
            n_tests++;
            if (seg !== exp_seg(8'h05, k) || an !== exp_an(k) || err !== 1'b0) begin
                n_fail++;
                $display("FAIL lead_zero k=%0d seg=%b an=%b err=%b required %b/%b/0",
                         k, seg, an, err, exp_seg(8'h05, k), exp_an(k));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_err();
        int vals [2] = '{8'h1C, 8'h09};
        foreach (vals[j]) begin
            send(vals[j]);
            for (int k = 0; k < 2 * DIV; k++) begin
                n_tests++;
                if (seg !== exp_seg(vals[j], k) || an !== exp_an(k) ||
                    err !== ref_err(vals[j])) begin
                    n_fail++;
                    $display("FAIL err_%h k=%0d seg=%b an=%b err=%b required %b/%b/%b",
                             vals[j], k, seg, an, err, exp_seg(vals[j], k), exp_an(k),
                             ref_err(vals[j]));
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            int v;
            int n;
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(0, 19);
                v = (n / 10) * 16 + (n % 10);
            end else begin
                v = $urandom_range(0, 255);
            end
            // Random idle time lands some transfers on a counter wrap.
            repeat ($urandom_range(0, 2 * DIV)) @(posedge clk);
            #1;
            send(v);
            for (int k = 0; k < 2 * DIV + 2; k++) begin
                n_tests++;
                if (seg !== exp_seg(v, k) || an !== exp_an(k) || err !== ref_err(v)) begin
                    n_fail++;
                    $display("FAIL random v=%h k=%0d seg=%b an=%b err=%b required %b/%b/%b",
                             v, k, seg, an, err, exp_seg(v, k), exp_an(k), ref_err(v));
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit model_ready = 1'b1;
        int acc = -1;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (sif.sum_ready !== model_ready) begin
                n_fail++;
                $display("FAIL b2b_ready i=%0d sum_ready=%b required=%b", i, sif.sum_ready, model_ready);
            end
            sif.sum_in    = 8'($urandom);
            sif.sum_valid = 1'b1;
            if (model_ready) begin
                acc = int'(sif.sum_in);
                model_ready = 1'b0;
            end else begin
                model_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        sif.sum_valid = 1'b0;
        for (int k = 0; k < 2 * DIV; k++) begin
            n_tests++;
            if (seg !== exp_seg(acc, k) || an !== exp_an(k) || err !== ref_err(acc)) begin
                n_fail++;
                $display("FAIL b2b_disp v=%h k=%0d seg=%b an=%b err=%b required %b/%b/%b",
                         acc, k, seg, an, err, exp_seg(acc, k), exp_an(k), ref_err(acc));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        send(8'h19);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (seg !== 7'h7F || an !== 2'b11 || err !== 1'b0 || sif.sum_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid seg=%b an=%b err=%b rdy=%b required 1111111/11/0/0",
                     seg, an, err, sif.sum_ready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (seg !== 7'h7F || an !== 2'b11 || sif.sum_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_idle_%0d seg=%b an=%b rdy=%b required 1111111/11/1",
                         i, seg, an, sif.sum_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_scan();
        test_leading_zero();
        test_err();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
